// File: rtl/reset_watchdog.sv
// reset_watchdog: countdown watchdog that requests a HOLD_CYCLES-long system reset on expiry.
// Define WATCHDOG_WARN_EN to build the registered early-warning output; otherwise warn_o is tied to 0.
module reset_watchdog #(
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 32,
    parameter int WARN_CYCLES = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             kick_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             clear_i,
    output logic             reset_req_o,
    output logic             expired_o,
    output logic             warn_o,
    output logic [CNT_W-1:0] count_o
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, reload;
    logic [7:0]       hold_q, hold_d;
    logic             req_q, req_d, exp_q, exp_d;
    assign reload = (timeout_i == '0) ? CNT_W'(1) : timeout_i;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                    count_d = reload;
                end
            end
            RUN: begin
                if (!enable_i) state_d = IDLE;
                else if (kick_i) count_d = reload;
                else if (count_q != '0) count_d = count_q - 1'b1;
                else begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (hold_q == 8'(HOLD_CYCLES)) begin
                    state_d = enable_i ? RUN : IDLE;
                    count_d = enable_i ? reload : count_q;
                end else hold_d = hold_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        // the entry cycle of HOLD is spent arming, so the request spans exactly HOLD_CYCLES cycles
        req_d = (state_q == HOLD) && (state_d == HOLD);
        exp_d = (state_q == RUN && state_d == HOLD) || (exp_q && !clear_i);
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            hold_q  <= '0;
            req_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
            exp_q   <= exp_d;
        end
    end
`ifdef WATCHDOG_WARN_EN
    logic warn_q, warn_d;
    assign warn_d = (state_d == RUN) && (count_d != '0) && (count_d <= CNT_W'(WARN_CYCLES));
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) warn_q <= 1'b0;
        else warn_q <= warn_d;
    end
    assign warn_o = warn_q;
`else
    assign warn_o = 1'b0;
`endif
    assign reset_req_o = req_q;
    assign expired_o   = exp_q;
    assign count_o     = count_q;
endmodule

// File: tb/tb_reset_watchdog.sv
// tb_reset_watchdog: directed and random checks of reset_watchdog against a behavioural model.
module tb_reset_watchdog;
    localparam int H = 32;
    localparam int W = 8;
`ifdef WATCHDOG_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif
    logic        clk_i = 1'b0, reset_i = 1'b1, enable_i = 1'b0, kick_i = 1'b0, clear_i = 1'b0;
    logic [15:0] timeout_i = 16'd10;
    logic        reset_req_o, expired_o, warn_o;
    logic [15:0] count_o;
    int total = 0, bad = 0;
    // model: phase 0 idle, 1 counting, 2 expired; arm marks the silent first cycle after expiry
    int m_phase, m_cnt, m_left;
    bit m_arm, m_req, m_exp, m_warn;

    reset_watchdog #(.CNT_W(16), .HOLD_CYCLES(H), .WARN_CYCLES(W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .kick_i(kick_i),
        .timeout_i(timeout_i), .clear_i(clear_i), .reset_req_o(reset_req_o),
        .expired_o(expired_o), .warn_o(warn_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int eff(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_left = 0; m_arm = 0;
        m_req = 0; m_exp = 0; m_warn = 0;
    endtask

    task automatic model_edge();
        bit expiring = 0;
        if (m_phase == 0) begin
            if (enable_i) begin m_phase = 1; m_cnt = eff(int'(timeout_i)); end
        end else if (m_phase == 1) begin
            if (!enable_i) m_phase = 0;
            else if (kick_i) m_cnt = eff(int'(timeout_i));
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin m_phase = 2; m_arm = 1; m_left = H; expiring = 1; end
        end else begin
            if (m_arm) m_arm = 0;
            else if (m_left == 1) begin
                m_phase = enable_i ? 1 : 0;
                if (enable_i) m_cnt = eff(int'(timeout_i));
            end else m_left = m_left - 1;
        end
        m_req  = (m_phase == 2) && !m_arm;
        m_exp  = expiring ? 1'b1 : (clear_i ? 1'b0 : m_exp);
        m_warn = WARN_EN && m_phase == 1 && m_cnt >= 1 && m_cnt <= W;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count_o), 32'(m_cnt));
        chk("reset_req", 32'(reset_req_o), 32'(m_req));
        chk("expired", 32'(expired_o), 32'(m_exp));
        chk("warn", 32'(warn_o), 32'(m_warn));
    endtask

    task automatic step();
        @(posedge clk_i);
        if (reset_i) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int rise, high, min_cnt, warns, n;
        model_reset();
        step();
        step();
        reset_i = 1'b0;
        // timeout 10, no kick: request rises 12 edges after enable and lasts H cycles
        enable_i = 1'b1; timeout_i = 16'd10;
        rise = -1; high = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (reset_req_o === 1'b1) begin
                high++;
                if (rise < 0) rise = i;
            end
        end
        chk("rise_cycle", 32'(rise), 32'd12);
        chk("hold_len", 32'(high), 32'(H));
        chk("expired_after_hold", 32'(expired_o), 32'd1);
        enable_i = 1'b0; clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        step();
        // periodic kicks keep the watchdog quiet
        enable_i = 1'b1; min_cnt = 1 << 20; high = 0;
        for (int i = 0; i < 1000; i++) begin
            kick_i = (i % 8 == 0) && (i != 0);
            step();
            if (int'(count_o) < min_cnt) min_cnt = int'(count_o);
            if (reset_req_o === 1'b1) high++;
        end
        kick_i = 1'b0;
        chk("kick_min_ge2", 32'(min_cnt >= 2), 32'd1);
        chk("kick_no_req", 32'(high), 32'd0);
        enable_i = 1'b0;
        step();
        // kick on the edge where the count is 0 wins over expiry
        enable_i = 1'b1; timeout_i = 16'd5;
        for (int i = 0; i < 6; i++) step();
        chk("zero_before_kick", 32'(count_o), 32'd0);
        kick_i = 1'b1;
        step();
        kick_i = 1'b0;
        chk("kick_reload", 32'(count_o), 32'd5);
        chk("kick_no_expire", 32'(expired_o), 32'd0);
        enable_i = 1'b0;
        step();
        // asynchronous reset in the middle of the request
        enable_i = 1'b1; timeout_i = 16'd3; n = 0;
        while (reset_req_o !== 1'b1 && n < 20) begin step(); n++; end
        chk("reached_hold", 32'(reset_req_o), 32'd1);
        for (int i = 0; i < 5; i++) step();
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        reset_i = 1'b0; enable_i = 1'b0;
        step();
        chk("idle_after_reset_req", 32'(reset_req_o), 32'd0);
        chk("idle_after_reset_exp", 32'(expired_o), 32'd0);
        // timeout 0 counts as 1; set beats clear on the expiry edge
        enable_i = 1'b1; timeout_i = 16'd0;
        step();
        chk("min_count", 32'(count_o), 32'd1);
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("set_beats_clear", 32'(expired_o), 32'd1);
        enable_i = 1'b0;
        for (int i = 0; i < H + 4; i++) step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        // early warning window with timeout 20
        enable_i = 1'b1; timeout_i = 16'd20; warns = 0;
        for (int i = 0; i < 21; i++) begin
            step();
            if (warn_o === 1'b1) warns++;
        end
        chk("warn_cycles", 32'(warns), WARN_EN ? 32'(W) : 32'd0);
        enable_i = 1'b0;
        step();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            enable_i  = $urandom_range(0, 19) != 0;
            kick_i    = $urandom_range(0, 9) == 0;
            clear_i   = $urandom_range(0, 29) == 0;
            timeout_i = 16'($urandom_range(0, 12));
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reset_watchdog.md
RESET_WATCHDOG -- requirements
Module: reset_watchdog

Interface
REQ-001 Parameter CNT_W, 16, width of the timeout counter and of timeout_i/count_o.
REQ-002 Parameter HOLD_CYCLES, 32, number of cycles reset_req_o is held high per expiry (legal range 1..255).
REQ-003 Parameter WARN_CYCLES, 8, warn_o asserts when the running count is at or below this value.
REQ-004 Port clk_i, input, 1, single system clock; all logic is on its rising edge.
REQ-005 Port reset_i, input, 1, asynchronous active-high reset.
REQ-006 Port enable_i, input, 1, watchdog run enable.
REQ-007 Port kick_i, input, 1, single-cycle service pulse that reloads the counter.
REQ-008 Port timeout_i, input, CNT_W, reload value, sampled only on a reload.
REQ-009 Port clear_i, input, 1, clears the sticky expired_o flag.
REQ-010 Port reset_req_o, output, 1, active-high reset request, HOLD_CYCLES cycles long, for the system reset generator.
REQ-011 Port expired_o, output, 1, sticky flag; at least one expiry has occurred since the last clear.
REQ-012 Port warn_o, output, 1, early-warning indication.
REQ-013 Port count_o, output, CNT_W, current counter value.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-015 IDLE -> RUN on the edge where enable_i=1; count_o loads timeout_i on that edge.
REQ-016 In RUN, an edge with kick_i=1 SHALL reload count_o from timeout_i.
REQ-017 In RUN, an edge with kick_i=0 and count_o>0 SHALL decrement count_o by 1.
REQ-018 In RUN, an edge with kick_i=0 and count_o=0 SHALL enter HOLD (expiry).
REQ-019 Kick and expiry on the same edge: the kick wins, so the counter reloads and no expiry occurs.
REQ-020 A timeout_i value of 0 SHALL be loaded as 1 (minimum loaded count of 1).
REQ-021 With timeout_i=T and a reload on edge k, reset_req_o SHALL first be 1 after edge k+T+2 if no further kick arrives.
REQ-022 In HOLD, reset_req_o=1 for exactly HOLD_CYCLES cycles, using an 8-bit hold counter; kick_i is ignored.
REQ-023 At the end of HOLD: if enable_i=1, go to RUN with count_o reloaded from timeout_i; otherwise go to IDLE.
REQ-024 enable_i=0 in RUN SHALL move to IDLE on the next edge; count_o holds its value there.
REQ-025 enable_i=0 in HOLD SHALL NOT shorten the hold.
REQ-026 reset_req_o SHALL be registered and glitch-free; it is 1 only in HOLD.
REQ-027 expired_o SHALL set on the edge entering HOLD and clear on an edge with clear_i=1; set wins if both occur on the same edge.
REQ-028 The counter SHALL never wrap below 0 or above its loaded value.

Reset
REQ-029 reset_i=1 SHALL asynchronously force the following: state=IDLE, count_o=0, hold counter=0, reset_req_o=0, expired_o=0, warn_o=0.
REQ-030 reset_i asserted mid-HOLD SHALL drop reset_req_o immediately; no hold is resumed after release.
REQ-031 After reset_i deasserts, the first state change SHALL occur no earlier than the next rising clk_i edge.

Configuration
REQ-032 Macro WATCHDOG_WARN_EN defined: warn_o is registered and equals 1 in RUN when count_o<=WARN_CYCLES and count_o>0 after the edge; otherwise 0.
REQ-033 Macro WATCHDOG_WARN_EN undefined: warn_o is constant 0, and no comparator logic is synthesized.

Verification
REQ-034 timeout_i=10, enable_i=1, no kick -> reset_req_o rises 12 cycles after enable and stays high for exactly 32 cycles; expired_o=1.
REQ-035 timeout_i=10, kick every 8 cycles for 1000 cycles -> reset_req_o never asserts; count_o never falls below 2.
REQ-036 Kick on the same edge where count_o=0 -> count_o=timeout_i next cycle, no HOLD, expired_o stays 0.
REQ-037 reset_i pulsed 5 cycles into HOLD -> reset_req_o=0 asynchronously; state IDLE, expired_o=0 after release.
REQ-038 WATCHDOG_WARN_EN defined, timeout_i=20 -> warn_o=1 exactly while count_o is 8..1; with the macro undefined, warn_o=0 throughout.
REQ-039 timeout_i=0, clear_i and expiry on the same edge -> effective count 1, and expired_o=1.
